// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared constants for the MIPS fetch stage and ControlUnit:
//                opcodes, funct codes, fetch FSM state and fault causes.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;

    // R-type funct codes, instr[5:0]
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_JALR = 6'h09;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    // Sticky fault cause reported to the core
    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_TIMEOUT  = 2'b01,
        CAUSE_MISALIGN = 2'b10
    } fault_cause_t;

    // Opcode field of an instruction word
    function automatic logic [5:0] get_opcode(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Instruction-memory request/ready bus between the fetch
//                stage (master) and the instruction memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;

    logic        req;    // request; addr held stable while high
    logic [31:0] addr;   // word address being fetched
    logic        ready;  // rdata valid, completes the request
    logic [31:0] rdata;  // fetched instruction word

    modport master (
        output req,
        output addr,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rdata
    );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_next_pc_calc.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_next_pc_calc
//  Description : Purely combinational next-PC selection for the held
//                instruction: jr/jalr, j/jal, taken branch or sequential.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit_next_pc_calc
    import fetch_unit_pkg::*;
(
    input  wire logic [31:0] pc_plus4,
    input  wire logic [31:0] instr,
    input  wire logic        branch,
    input  wire logic        jump,
    input  wire logic        branch_taken,
    input  wire logic [31:0] rs_value,
    output logic      [31:0] next_pc
);

    logic [5:0]  w_opcode;
    logic [31:0] w_jump_target;
    logic [31:0] w_branch_offset;

    // Jump beats branch; everything wraps modulo 2^32
    always_comb begin
        w_opcode        = get_opcode(instr);
        w_jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
        w_branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
        next_pc         = pc_plus4;
        if (jump && (w_opcode == OP_RTYPE)) begin
            next_pc = rs_value;
        end else if (jump && ((w_opcode == OP_J) || (w_opcode == OP_JAL))) begin
            next_pc = w_jump_target;
        end else if (branch && branch_taken) begin
            next_pc = pc_plus4 + w_branch_offset;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : MIPS instruction-fetch stage. Owns the PC, fetches from a
//                variable-latency memory, holds one instruction for decode
//                until commit, then advances to the computed next PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    fetch_unit_if.master     imem,
    output logic      [31:0] instr,
    output logic             instr_valid,
    input  wire logic        commit,
    input  wire logic        branch,
    input  wire logic        jump,
    input  wire logic        branch_taken,
    input  wire logic [31:0] rs_value,
    output logic      [31:0] pc,
    output logic      [31:0] pc_plus4,
    output logic             fault,
    output logic      [1:0]  fault_cause
);

    // Counter only needs to reach TIMEOUT_CYC-1
    localparam int C_CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    fault_cause_t r_cause;
    fault_cause_t w_cause_next;
    logic         w_cause_we;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_next_pc;
    logic         w_req;
    logic         w_valid;
    logic         w_load_instr;
    logic         w_load_pc;
    logic         w_timeout;

    assign w_pc_plus4 = r_pc + 32'd4;

    fetch_unit_next_pc_calc u_next_pc_calc (
        .pc_plus4     (w_pc_plus4),
        .instr        (r_instr),
        .branch       (branch),
        .jump         (jump),
        .branch_taken (branch_taken),
        .rs_value     (rs_value),
        .next_pc      (w_next_pc)
    );

    generate
        if (TIMEOUT_CYC != 0) begin : g_timeout
            logic [C_CNT_W-1:0] r_cnt;

            // Count unanswered request cycles; cleared when memory responds
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (r_state == ST_REQ) begin
                    if (imem.ready) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_timeout = (r_cnt == C_CNT_W'(TIMEOUT_CYC - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // State register; async reset forces IDLE so imem_req drops at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-state strobes
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_valid      = 1'b0;
        w_load_instr = 1'b0;
        w_load_pc    = 1'b0;
        w_cause_we   = 1'b0;
        w_cause_next = CAUSE_NONE;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_REQ;
            end
            ST_REQ: begin
                w_req = 1'b1;
                if (imem.ready) begin
                    w_load_instr = 1'b1;
                    w_state_next = ST_ISSUE;
                end else if (w_timeout) begin
                    w_cause_we   = 1'b1;
                    w_cause_next = CAUSE_TIMEOUT;
                    w_state_next = ST_FAULT;
                end
            end
            ST_ISSUE: begin
                w_valid = 1'b1;
                if (commit) begin
                    // PC takes the target even when it is misaligned
                    w_load_pc = 1'b1;
                    if (w_next_pc[1:0] != 2'b00) begin
                        w_cause_we   = 1'b1;
                        w_cause_next = CAUSE_MISALIGN;
                        w_state_next = ST_FAULT;
                    end else begin
                        w_state_next = ST_REQ;
                    end
                end
            end
            ST_FAULT: begin
                w_state_next = ST_FAULT;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // PC, held instruction and sticky fault cause
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_instr <= 32'h0000_0000;
            r_cause <= CAUSE_NONE;
        end else begin
            if (w_load_pc) begin
                r_pc <= w_next_pc;
            end
            if (w_load_instr) begin
                r_instr <= imem.rdata;
            end
            if (w_cause_we) begin
                r_cause <= w_cause_next;
            end
        end
    end

    assign imem.req    = w_req;
    assign imem.addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = w_valid;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign fault       = (r_state == ST_FAULT);
    assign fault_cause = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit: reset state, fetch
//                handshake, next-PC vectors, misalignment and timeout faults.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] C_ADD = 32'h0022_1820;  // add $3,$1,$2
    localparam logic [31:0] C_JR  = 32'h00A0_0008;  // jr  $5

    typedef struct {
        logic [31:0] pc0;
        logic [31:0] word;
        logic        b;
        logic        j;
        logic        t;
        logic [31:0] rs;
        logic [31:0] exp_p4;
        logic [31:0] exp_next;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rst_n_t;
    logic [31:0] instr, pc, pc_plus4, rs_value;
    logic        instr_valid, commit, branch, jump, branch_taken, fault;
    logic [1:0]  fault_cause;
    logic [31:0] instr_t, pc_t, pc_plus4_t;
    logic        instr_valid_t, fault_t;
    logic [1:0]  fault_cause_t;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] cur_pc;
    vec_t vecs [10];

    fetch_unit_if imem_a ();
    fetch_unit_if imem_t ();

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem         (imem_a),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .commit       (commit),
        .branch       (branch),
        .jump         (jump),
        .branch_taken (branch_taken),
        .rs_value     (rs_value),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .fault        (fault),
        .fault_cause  (fault_cause)
    );

    fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYC(4)) dut_t (
        .clk          (clk),
        .rst_n        (rst_n_t),
        .imem         (imem_t),
        .instr        (instr_t),
        .instr_valid  (instr_valid_t),
        .commit       (1'b0),
        .branch       (1'b0),
        .jump         (1'b0),
        .branch_taken (1'b0),
        .rs_value     (32'h0),
        .pc           (pc_t),
        .pc_plus4     (pc_plus4_t),
        .fault        (fault_t),
        .fault_cause  (fault_cause_t)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for a request at exp_addr, stall `delay` cycles, then return word
    task automatic fetch(input logic [31:0] word, input int delay,
                         input logic [31:0] exp_addr, input string tag);
        int waited = 0;
        while (!imem_a.req && waited < 20) begin
            step();
            waited++;
        end
        chk({tag, " req"}, {31'b0, imem_a.req}, 32'd1);
        chk({tag, " addr"}, imem_a.addr, exp_addr);
        for (int d = 0; d < delay; d++) begin
            imem_a.ready = 1'b0;
            commit       = 1'b1;   // must be ignored while fetching
            if (d > 0) begin
                chk({tag, " wait req"}, {31'b0, imem_a.req}, 32'd1);
                chk({tag, " wait addr"}, imem_a.addr, exp_addr);
                chk({tag, " wait valid"}, {31'b0, instr_valid}, 32'd0);
            end
            step();
        end
        commit       = 1'b0;
        imem_a.ready = 1'b1;
        imem_a.rdata = word;
        step();
        imem_a.ready = 1'b0;
        imem_a.rdata = 32'hDEAD_BEEF;
        chk({tag, " valid"}, {31'b0, instr_valid}, 32'd1);
        chk({tag, " instr"}, instr, word);
    endtask

    task automatic do_commit(input logic b, input logic j, input logic t, input logic [31:0] rs);
        branch       = b;
        jump         = j;
        branch_taken = t;
        rs_value     = rs;
        commit       = 1'b1;
        step();
        commit       = 1'b0;
        branch       = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        rs_value     = 32'h0;
    endtask

    // Redirect the PC with a jr from wherever it currently is
    task automatic goto_pc(input logic [31:0] target);
        fetch(C_JR, 0, cur_pc, "goto");
        do_commit(1'b0, 1'b1, 1'b0, target);
        cur_pc = target;
    endtask

    initial begin
        int req_cnt;
        int req_seen;

        vecs[0] = '{32'h0000_0020, 32'h1022_FFFE, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0024, 32'h0000_001C};
        vecs[1] = '{32'h0000_0020, 32'h1022_FFFE, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0024, 32'h0000_0024};
        vecs[2] = '{32'hF000_0000, 32'h0800_0100, 1'b0, 1'b1, 1'b0, 32'h0, 32'hF000_0004, 32'hF000_0400};
        vecs[3] = '{32'hF000_0000, 32'h0C00_0100, 1'b0, 1'b1, 1'b0, 32'h0, 32'hF000_0004, 32'hF000_0400};
        vecs[4] = '{32'h0000_0100, 32'h1464_0010, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0104, 32'h0000_0144};
        vecs[5] = '{32'hFFFF_FFFC, C_ADD,         1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 32'h0000_0000};
        vecs[6] = '{32'h0000_0040, C_JR,          1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_0044, 32'h0000_2000};
        vecs[7] = '{32'h0000_0040, 32'h0800_0020, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0000_0044, 32'h0000_0080};
        vecs[8] = '{32'h0000_0004, 32'h1000_FFFC, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0008, 32'hFFFF_FFF8};
        vecs[9] = '{32'h0000_0200, 32'h1000_FFFC, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0204, 32'h0000_0204};

        rst_n        = 1'b0;
        rst_n_t      = 1'b0;
        commit       = 1'b0;
        branch       = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        rs_value     = 32'h0;
        imem_a.ready = 1'b0;
        imem_a.rdata = 32'h0;
        imem_t.ready = 1'b0;
        imem_t.rdata = 32'h0;
        repeat (3) step();

        // Reset state
        chk("rst req", {31'b0, imem_a.req}, 32'd0);
        chk("rst valid", {31'b0, instr_valid}, 32'd0);
        chk("rst fault", {31'b0, fault}, 32'd0);
        chk("rst cause", {30'b0, fault_cause}, 32'd0);
        chk("rst pc", pc, 32'h0);
        chk("rst instr", instr, 32'h0);
        chk("rst pc_plus4", pc_plus4, 32'h4);
        chk("rst req_t", {31'b0, imem_t.req}, 32'd0);

        // Ready already high when the first request appears
        imem_a.ready = 1'b1;
        imem_a.rdata = C_ADD;
        rst_n        = 1'b1;
        chk("idle req", {31'b0, imem_a.req}, 32'd0);
        step();
        chk("first req", {31'b0, imem_a.req}, 32'd1);
        chk("first addr", imem_a.addr, 32'h0);
        step();
        imem_a.ready = 1'b0;
        chk("min lat valid", {31'b0, instr_valid}, 32'd1);
        chk("min lat instr", instr, C_ADD);
        do_commit(1'b0, 1'b0, 1'b0, 32'h0);
        chk("seq req", {31'b0, imem_a.req}, 32'd1);
        chk("seq addr", imem_a.addr, 32'h4);
        cur_pc = 32'h4;

        // Five-cycle stall at 0x10, then hold steady through ISSUE
        goto_pc(32'h10);
        fetch(C_ADD, 5, 32'h10, "stall");
        chk("stall fault", {31'b0, fault}, 32'd0);
        chk("stall pc", pc, 32'h10);
        imem_a.ready = 1'b1;
        imem_a.rdata = 32'h1234_5678;
        repeat (3) step();
        imem_a.ready = 1'b0;
        chk("hold instr", instr, C_ADD);
        chk("hold pc", pc, 32'h10);
        chk("hold valid", {31'b0, instr_valid}, 32'd1);
        chk("hold req", {31'b0, imem_a.req}, 32'd0);
        do_commit(1'b0, 1'b0, 1'b0, 32'h0);
        chk("after stall addr", imem_a.addr, 32'h14);
        cur_pc = 32'h14;

        // Next-PC vectors
        for (int i = 0; i < 10; i++) begin
            goto_pc(vecs[i].pc0);
            fetch(vecs[i].word, 0, cur_pc, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d pc", i), pc, vecs[i].pc0);
            chk($sformatf("vec%0d pc_plus4", i), pc_plus4, vecs[i].exp_p4);
            do_commit(vecs[i].b, vecs[i].j, vecs[i].t, vecs[i].rs);
            chk($sformatf("vec%0d next req", i), {31'b0, imem_a.req}, 32'd1);
            chk($sformatf("vec%0d next addr", i), imem_a.addr, vecs[i].exp_next);
            cur_pc = vecs[i].exp_next;
        end

        // Misaligned jr target faults, PC still moves, no more fetches
        fetch(C_JR, 0, cur_pc, "misalign");
        do_commit(1'b0, 1'b1, 1'b0, 32'h0000_0102);
        chk("mis fault", {31'b0, fault}, 32'd1);
        chk("mis cause", {30'b0, fault_cause}, 32'd2);
        chk("mis pc", pc, 32'h0000_0102);
        imem_a.ready = 1'b1;
        req_seen = 0;
        for (int k = 0; k < 10; k++) begin
            commit = 1'b1;
            step();
            if (imem_a.req || instr_valid) req_seen++;
        end
        commit       = 1'b0;
        imem_a.ready = 1'b0;
        chk("mis stuck", req_seen, 0);
        chk("mis still fault", {31'b0, fault}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mis rst fault", {31'b0, fault}, 32'd0);
        chk("mis rst cause", {30'b0, fault_cause}, 32'd0);
        chk("mis rst pc", pc, 32'h0);
        step();
        rst_n = 1'b1;

        // Timeout after four unanswered request cycles
        rst_n_t = 1'b1;
        req_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (fault_t) break;
            if (imem_t.req) req_cnt++;
        end
        chk("to req cycles", req_cnt, 4);
        chk("to fault", {31'b0, fault_t}, 32'd1);
        chk("to cause", {30'b0, fault_cause_t}, 32'd1);
        chk("to req low", {31'b0, imem_t.req}, 32'd0);

        // Asynchronous reset mid-request drops req immediately
        rst_n_t = 1'b0;
        step();
        rst_n_t = 1'b1;
        step();
        step();
        chk("abort req before", {31'b0, imem_t.req}, 32'd1);
        #2;
        rst_n_t = 1'b0;
        #1;
        chk("abort req after", {31'b0, imem_t.req}, 32'd0);
        chk("abort fault", {31'b0, fault_t}, 32'd0);
        step();
        rst_n_t = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop in case a bounded wait is ever bypassed
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
